fifo_rd_packer: RTL and testbench

- Read-side consumer of the asynchronous FIFO, in the read clock domain.
- Pops words through the FIFO's r_en/empty/dout interface and presents them as a valid/ready stream.
- Frames the stream into packets of PKT_LEN words, with m_last on the final word.
- Closes a short packet when the FIFO stays idle for TIMEOUT cycles, so a partial packet never stalls.

---
 rtl/fifo_rd_packer.sv | 136 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops words into a 2-entry buffer and streams them as PKT_LEN-word packets,
// closing short packets after TIMEOUT idle cycles. Define FIFO_RD_PACKER_STATS_EN for packet counters.
module fifo_rd_packer #(
  parameter int data_width = 8,
  parameter int PKT_LEN    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_dout,
  output logic                  fifo_r_en,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
`ifdef FIFO_RD_PACKER_STATS_EN
  ,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           short_cnt
`endif
);

  localparam logic [7:0] LAST_BEAT = 8'(PKT_LEN - 1);
  localparam logic [7:0] TMO       = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_PRESENT} state_t;

  // Stream handshake: a beat transfers on a rising clk edge with m_valid && m_ready; once m_valid is
  // raised, m_valid/m_data/m_last stay constant until that transfer.
  state_t                state, state_n;
  logic [data_width-1:0] head_q, tail_q, head_n, tail_n;
  logic [1:0]            occ, occ_n;
  logic                  inflight;
  logic [7:0]            beat_cnt, beat_n;
  logic [7:0]            idle_cnt, idle_n;
  logic                  last_q, last_n;
  logic                  pop_out, hold, present_n;
  logic                  cond_ab, cond_c, cond_d;

  assign m_valid = (state == S_PRESENT);
  assign m_data  = head_q;
  assign m_last  = last_q;

  always_comb begin
    pop_out   = m_valid && m_ready;
    // occ + inflight never exceeds 2, so the buffer cannot overflow.
    fifo_r_en = !rst && !fifo_empty &&
                (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop_out}));
    head_n = head_q;
    tail_n = tail_q;
    occ_n  = occ;
    case ({inflight, pop_out})
      2'b11: begin
        if (occ == 2'd2) begin
          head_n = tail_q;
          tail_n = fifo_dout;
        end else begin
          head_n = fifo_dout;
        end
      end
      2'b10: begin
        if (occ == 2'd0) head_n = fifo_dout;
        else             tail_n = fifo_dout;
        occ_n = occ + 2'd1;
      end
      2'b01: begin
        head_n = tail_q;
        occ_n  = occ - 2'd1;
      end
      default: ;
    endcase

    beat_n = beat_cnt;
    if (pop_out) beat_n = last_q ? 8'd0 : beat_cnt + 8'd1;

    idle_n = idle_cnt;
    if (inflight || pop_out)
      idle_n = 8'd0;
    else if (occ == 2'd1 && fifo_empty && !m_valid && idle_cnt != TMO)
      idle_n = idle_cnt + 8'd1;

    // A successor (buffered or in flight) never closes the packet; only beat count or timeout does.
    cond_ab   = (occ_n == 2'd2) || fifo_r_en;
    cond_c    = (beat_n == LAST_BEAT);
    cond_d    = (idle_n == TMO);
    hold      = m_valid && !pop_out;
    present_n = hold || ((occ_n != 2'd0) && (cond_ab || cond_c || cond_d));
    last_n    = hold ? last_q : (present_n && (cond_c || !cond_ab));

    if (present_n)          state_n = S_PRESENT;
    else if (occ_n == 2'd0) state_n = S_EMPTY;
    else                    state_n = S_HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat_cnt <= 8'd0;
      idle_cnt <= 8'd0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_n;
      head_q   <= head_n;
      tail_q   <= tail_n;
      occ      <= occ_n;
      inflight <= fifo_r_en;
      beat_cnt <= beat_n;
      idle_cnt <= idle_n;
      last_q   <= last_n;
    end
  end

`ifdef FIFO_RD_PACKER_STATS_EN
  logic short_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      short_q   <= 1'b0;
      pkt_cnt   <= 16'd0;
      short_cnt <= 16'd0;
    end else begin
      short_q <= hold ? short_q : (present_n && !cond_c && !cond_ab);
      if (pop_out && last_q) begin
        pkt_cnt <= pkt_cnt + 16'd1;
        if (short_q) short_cnt <= short_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO stand-in, packet-level scoreboard, directed and random traffic.
module tb_fifo_rd_packer;
  localparam int W       = 8;
  localparam int EW      = W + 1;
  localparam int PKT_LEN = 4;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_dout = '0;
  logic         fifo_r_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
`ifdef FIFO_RD_PACKER_STATS_EN
  logic [15:0]  pkt_cnt, short_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_packer #(.data_width(W), .PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_r_en(fifo_r_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef FIFO_RD_PACKER_STATS_EN
    , .pkt_cnt(pkt_cnt), .short_cnt(short_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];   // {last, data} of every beat still owed by the DUT
  logic [W-1:0]  fifo_q[$];
  logic [EW-1:0] acc_log[$];
  int            acc_cyc[$];
  logic          push_en = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          r_en_s = 1'b0;
  int n_acc = 0, n_popped = 0, cyc = 0;
  int exp_idx = 0, del_idx = 0, exp_pkts = 0, exp_shorts = 0;
  int ready_mode = 0;
  logic          prev_hold = 1'b0;
  logic [W-1:0]  prev_data = '0;
  logic          prev_last = 1'b0;

  // FIFO stand-in: dout is registered one clk after an accepted pop; pushes become visible next edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      fifo_q.delete();
      n_popped = n_acc;
    end else if (r_en_s && !fifo_empty) begin
      fifo_dout <= fifo_q.pop_front();
      n_popped++;
    end
    if (push_en) fifo_q.push_back(push_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: sampled mid-cycle, every cycle out of reset.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    r_en_s = fifo_r_en;
    if (rst) begin
      prev_hold  = 1'b0;
      del_idx    = 0;
      exp_pkts   = 0;
      exp_shorts = 0;
    end else begin
      checks++;
      if (fifo_r_en && fifo_empty) begin
        errors++;
        $display("FAIL pop_on_empty: fifo_r_en=%0b while fifo_empty=1 (required 0)", fifo_r_en);
      end
      checks++;
      if (n_popped - n_acc > 2) begin
        errors++;
        $display("FAIL occupancy: %0d words held or in flight, required <= 2", n_popped - n_acc);
      end
      if (prev_hold) begin
        checks++;
        if (!m_valid || m_data !== prev_data || m_last !== prev_last) begin
          errors++;
          $display("FAIL stable: got v=%0b d=%h l=%0b, required v=1 d=%h l=%0b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: got d=%h l=%0b, required no beat", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            errors++;
            $display("FAIL beat: got d=%h l=%0b, required d=%h l=%0b", m_data, m_last, e[W-1:0], e[W]);
          end
          if (e[W]) begin
            exp_pkts++;
            if (del_idx != PKT_LEN - 1) exp_shorts++;
            del_idx = 0;
          end else begin
            del_idx++;
          end
        end
        n_acc++;
        acc_log.push_back({m_last, m_data});
        acc_cyc.push_back(cyc);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Model: a word closes its packet when it is the PKT_LEN-th beat or the last word before idle.
  task automatic push_word(input logic [W-1:0] d, input bit end_of_burst);
    bit last;
    last = (exp_idx == PKT_LEN - 1) || end_of_burst;
    exp_q.push_back({last, d});
    exp_idx = last ? 0 : exp_idx + 1;
    push_en   = 1'b1;
    push_data = d;
    tick(1);
    push_en = 1'b0;
  endtask

  task automatic send_burst(input logic [W-1:0] base, input int n, input int gmax, input bit rnd);
    for (int i = 0; i < n; i++) begin
      push_word(rnd ? W'($urandom) : base + W'(i), i == n - 1);
      if (i != n - 1) tick($urandom_range(0, gmax));
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (n_acc < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("accept_wait", n_acc, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_idx = 0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_r_en", int'(fifo_r_en), 0);
    check("rst_valid", int'(m_valid), 0);
    check("rst_last", int'(m_last), 0);
    check("rst_data", int'(m_data), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k0, hold;
    do_reset();

    // Full packets at full rate
    ready_mode = 0;
    k0 = acc_log.size();
    send_burst(8'h10, 8, 0, 1'b0);
    drain(200);
    check("full_count", acc_log.size() - k0, 8);
    if (acc_log.size() - k0 == 8) begin
      for (int i = 0; i < 8; i++)
        check("full_beat", int'(acc_log[k0 + i]), int'({i % 4 == 3, 8'(8'h10 + i)}));
      check("full_rate", acc_cyc[k0 + 7] - acc_cyc[k0], 7);
    end

    // Backpressure
    ready_mode = 1;
    send_burst(8'h20, 8, 0, 1'b0);
    drain(300);

    // Timeout close
    ready_mode = 0;
    tick(3);
    k0 = n_acc;
    send_burst(8'hA0, 3, 0, 1'b0);
    wait_acc(k0 + 2);
    hold = 0;
    while (hold < 100) begin
      @(negedge clk);
      if (m_valid) break;
      hold++;
    end
    check("timeout_hold", hold, TIMEOUT);
    check("timeout_data", int'(m_data), 'hA2);
    check("timeout_last", int'(m_last), 1);
    @(posedge clk);
    #1;
    drain(100);
    send_burst(8'hB0, 4, 0, 1'b0);
    drain(200);

    // Late arrival below the timeout
    push_word(8'h30, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("late_no_valid", int'(m_valid), 0);
    end
    @(posedge clk);
    #1;
    push_word(8'h31, 1'b1);
    drain(200);

    // Reset mid-packet
    k0 = n_acc;
    send_burst(8'h40, 4, 0, 1'b0);
    wait_acc(k0 + 2);
    #1;
    do_reset();
    send_burst(8'h50, 4, 0, 1'b0);
    drain(200);
    send_burst(8'h60, 2, 0, 1'b0);
    drain(200);

`ifdef FIFO_RD_PACKER_STATS_EN
    tick(2);
    check("pkt_cnt", int'(pkt_cnt), 2);
    check("short_cnt", int'(short_cnt), 1);
`endif

    // Random traffic
    ready_mode = 2;
    for (int b = 0; b < 25; b++) begin
      send_burst('0, $urandom_range(1, 9), 3, 1'b1);
      drain(800);
      tick($urandom_range(0, 5));
    end

`ifdef FIFO_RD_PACKER_STATS_EN
    tick(2);
    check("pkt_cnt_total", int'(pkt_cnt), exp_pkts % 65536);
    check("short_cnt_total", int'(short_cnt), exp_shorts % 65536);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
